// File: rtl/rpc_mq_pkg.sv
// Shared definitions for the multi-port RPC unit: port-index width helper,
// default widths, the TX beat layout and the drop counter width.
package rpc_mq_pkg;

  localparam int DROP_CNT_W  = 32;
  localparam int DEF_N_PORTS = 4;
  localparam int DEF_RPC_W   = 512;
  localparam int DEF_FLOW_W  = 16;
  localparam int DEF_ADDR_W  = 96;

  // Port index width; a single-port build still carries a 1-bit index.
  function automatic int calc_pw(input int n_ports);
    return (n_ports <= 1) ? 1 : $clog2(n_ports);
  endfunction

  localparam int DEF_PW = calc_pw(DEF_N_PORTS);

  typedef struct packed {
    logic [DEF_RPC_W-1:0]  data;
    logic [DEF_FLOW_W-1:0] flow;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_PW-1:0]     port;
  } tx_beat_t;

endpackage

// File: rtl/rpc_mq_if.sv
// Bundle of CPU-side and network-side signals of rpc_mq. The slave modport is
// the RPC unit; the master modport is whatever drives it.
interface rpc_mq_if
  import rpc_mq_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int RPC_W   = DEF_RPC_W,
  parameter int FLOW_W  = DEF_FLOW_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int PW      = calc_pw(N_PORTS)
);

  logic [N_PORTS-1:0]        port_en_in;
  logic [N_PORTS-1:0]        rpc_valid_in;
  logic [N_PORTS-1:0]        rpc_ready_out;
  logic [N_PORTS*RPC_W-1:0]  rpc_data_in;
  logic [N_PORTS*FLOW_W-1:0] rpc_flow_in;
  logic [N_PORTS*ADDR_W-1:0] rpc_addr_in;

  logic                      net_tx_valid_out;
  logic                      net_tx_ready_in;
  logic [RPC_W-1:0]          net_tx_data_out;
  logic [FLOW_W-1:0]         net_tx_flow_out;
  logic [ADDR_W-1:0]         net_tx_addr_out;
  logic [PW-1:0]             net_tx_port_out;

  logic                      net_rx_valid_in;
  logic [RPC_W-1:0]          net_rx_data_in;
  logic [FLOW_W-1:0]         net_rx_flow_in;
  logic [ADDR_W-1:0]         net_rx_addr_in;

  logic [N_PORTS-1:0]        rpc_valid_out;
  logic [RPC_W-1:0]          rpc_data_out;
  logic [FLOW_W-1:0]         rpc_flow_out;
  logic [DROP_CNT_W-1:0]     drop_cnt_out;
  logic                      error;

  modport slave (
    input  port_en_in, rpc_valid_in, rpc_data_in, rpc_flow_in, rpc_addr_in,
    input  net_tx_ready_in,
    input  net_rx_valid_in, net_rx_data_in, net_rx_flow_in, net_rx_addr_in,
    output rpc_ready_out,
    output net_tx_valid_out, net_tx_data_out, net_tx_flow_out, net_tx_addr_out,
    output net_tx_port_out,
    output rpc_valid_out, rpc_data_out, rpc_flow_out, drop_cnt_out, error
  );

  modport master (
    output port_en_in, rpc_valid_in, rpc_data_in, rpc_flow_in, rpc_addr_in,
    output net_tx_ready_in,
    output net_rx_valid_in, net_rx_data_in, net_rx_flow_in, net_rx_addr_in,
    input  rpc_ready_out,
    input  net_tx_valid_out, net_tx_data_out, net_tx_flow_out, net_tx_addr_out,
    input  net_tx_port_out,
    input  rpc_valid_out, rpc_data_out, rpc_flow_out, drop_cnt_out, error
  );

endinterface

// File: rtl/rpc_mq_fifo.sv
// Synchronous FIFO for one TX channel. Pointers wrap naturally at DEPTH
// (power of two); push while full and pop while empty are ignored.
module rpc_mq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rpc_mq.sv
// Multi-port RPC unit: per-port TX FIFOs merged round-robin into one stallable
// network TX register, and RX beats steered to a port by flow ID.
module rpc_mq
  import rpc_mq_pkg::*;
#(
  parameter int NIC_ID     = 0,
  parameter int N_PORTS    = DEF_N_PORTS,
  parameter int FIFO_DEPTH = 8,
  parameter int RPC_W      = DEF_RPC_W,
  parameter int FLOW_W     = DEF_FLOW_W,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input logic     clk,
  input logic     reset,
  rpc_mq_if.slave bus
);

  localparam int PW = calc_pw(N_PORTS);

  if (N_PORTS < 1 || N_PORTS > 16 || (N_PORTS & (N_PORTS - 1)) != 0) begin : g_bad_ports
    $error("rpc_mq: N_PORTS must be a power of 2 in 1..16");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rpc_mq: FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (FLOW_W < PW || NIC_ID < 0) begin : g_bad_misc
    $error("rpc_mq: FLOW_W must cover the port index and NIC_ID must be non-negative");
  end

  typedef struct packed {
    logic [RPC_W-1:0]  data;
    logic [FLOW_W-1:0] flow;
    logic [ADDR_W-1:0] addr;
    logic [PW-1:0]     port;
  } beat_t;

  beat_t              fifo_out [N_PORTS];
  logic [N_PORTS-1:0] full, empty, ready, push, pop, cand;
  logic [PW-1:0]      last_grant;
  logic [PW-1:0]      grant_idx;
  logic               grant_vld;
  logic               load;
  beat_t              tx_q;
  logic               tx_vld;

  // Ready is gated by reset so nothing is accepted while the unit is held.
  assign ready = bus.port_en_in & ~full & {N_PORTS{~reset}};
  assign cand  = ~empty & bus.port_en_in;
  assign load  = grant_vld & (~tx_vld | bus.net_tx_ready_in);

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    beat_t beat_in;
    assign beat_in.data = bus.rpc_data_in[p*RPC_W +: RPC_W];
    assign beat_in.flow = bus.rpc_flow_in[p*FLOW_W +: FLOW_W];
    assign beat_in.addr = bus.rpc_addr_in[p*ADDR_W +: ADDR_W];
    assign beat_in.port = PW'(p);
    assign push[p]      = bus.rpc_valid_in[p] & ready[p];
    assign pop[p]       = load & (grant_idx == PW'(p));

    rpc_mq_fifo #(
      .WIDTH ($bits(beat_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[p]),
      .pop   (pop[p]),
      .din   (beat_in),
      .dout  (fifo_out[p]),
      .full  (full[p]),
      .empty (empty[p])
    );
  end

  // Round-robin search starting just after the last granted port.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = last_grant + PW'(i + 1);
      if (N_PORTS == 1) idx = '0;
      if (!grant_vld && cand[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_vld     <= 1'b0;
      tx_q       <= '0;
      last_grant <= PW'(N_PORTS - 1);
    end else if (!tx_vld || bus.net_tx_ready_in) begin
      tx_vld <= grant_vld;
      if (grant_vld) begin
        tx_q       <= fifo_out[grant_idx];
        last_grant <= grant_idx;
      end
    end
  end

  assign bus.net_tx_valid_out = tx_vld;
  assign bus.net_tx_data_out  = tx_q.data;
  assign bus.net_tx_flow_out  = tx_q.flow;
  assign bus.net_tx_addr_out  = tx_q.addr;
  assign bus.net_tx_port_out  = tx_q.port;

  logic [PW-1:0]         rx_port;
  logic                  rx_en;
  logic [N_PORTS-1:0]    rx_strobe;
  logic [RPC_W-1:0]      rx_data;
  logic [FLOW_W-1:0]     rx_flow;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  error_q;
  logic                  unused_rx;

  assign rx_port   = (N_PORTS == 1) ? '0 : bus.net_rx_flow_in[PW-1:0];
  assign rx_en     = bus.port_en_in[rx_port];
  assign unused_rx = ^{bus.net_rx_addr_in, bus.net_rx_flow_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_strobe <= '0;
      rx_data   <= '0;
      rx_flow   <= '0;
      drop_cnt  <= '0;
      error_q   <= 1'b0;
    end else begin
      rx_strobe <= '0;
      if (bus.net_rx_valid_in) begin
        if (rx_en) begin
          rx_strobe <= N_PORTS'(1) << rx_port;
          rx_data   <= bus.net_rx_data_in;
          rx_flow   <= bus.net_rx_flow_in;
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
      if (|(bus.rpc_valid_in & ~bus.port_en_in)) error_q <= 1'b1;
    end
  end

  assign bus.rpc_ready_out = ready;
  assign bus.rpc_valid_out = rx_strobe;
  assign bus.rpc_data_out  = rx_data;
  assign bus.rpc_flow_out  = rx_flow;
  assign bus.drop_cnt_out  = drop_cnt;
  assign bus.error         = error_q;

endmodule

// File: tb/tb_rpc_mq.sv
// Directed bench for rpc_mq: RX steering vector table plus hand-written TX,
// backpressure, violation and mid-stall reset sequences.
module tb_rpc_mq;
  import rpc_mq_pkg::*;

  localparam int NP = 4;
  localparam int RW = 512;
  localparam int FW = 16;
  localparam int AW = 96;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rpc_mq_if #(.N_PORTS(NP), .RPC_W(RW), .FLOW_W(FW), .ADDR_W(AW)) bus ();

  rpc_mq #(
    .NIC_ID(0), .N_PORTS(NP), .FIFO_DEPTH(8), .RPC_W(RW), .FLOW_W(FW), .ADDR_W(AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  en;
    logic        vld;
    logic [15:0] flow;
    logic [3:0]  exp_strobe;
    logic [31:0] exp_drop;
  } rx_vec_t;

  rx_vec_t rx_vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [15:0] flow);
    bus.rpc_data_in[p*RW +: RW] = {32{flow}};
    bus.rpc_flow_in[p*FW +: FW] = flow;
    bus.rpc_addr_in[p*AW +: AW] = {6{flow}};
  endtask

  task automatic check_tx(input string name, input logic [1:0] port, input logic [15:0] flow);
    tx_beat_t exp_b;
    tx_beat_t got_b;
    exp_b.data = {32{flow}};
    exp_b.flow = flow;
    exp_b.addr = {6{flow}};
    exp_b.port = port;
    got_b.data = bus.net_tx_data_out;
    got_b.flow = bus.net_tx_flow_out;
    got_b.addr = bus.net_tx_addr_out;
    got_b.port = bus.net_tx_port_out;
    check({name, "_valid"}, 640'(bus.net_tx_valid_out), 640'(1'b1));
    check(name, 640'(got_b), 640'(exp_b));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus.rpc_valid_in    = '0;
    bus.net_rx_valid_in = 1'b0;
    bus.port_en_in      = 4'hF;
  endtask

  initial begin
    reset               = 1'b1;
    bus.port_en_in      = 4'hF;
    bus.rpc_valid_in    = '0;
    bus.rpc_data_in     = '0;
    bus.rpc_flow_in     = '0;
    bus.rpc_addr_in     = '0;
    bus.net_tx_ready_in = 1'b1;
    bus.net_rx_valid_in = 1'b0;
    bus.net_rx_data_in  = '0;
    bus.net_rx_flow_in  = '0;
    bus.net_rx_addr_in  = '0;

    rx_vecs[0] = '{4'hF, 1'b1, 16'h0005, 4'b0010, 32'd0};
    rx_vecs[1] = '{4'hF, 1'b1, 16'h0012, 4'b0100, 32'd0};
    rx_vecs[2] = '{4'hF, 1'b0, 16'h0001, 4'b0000, 32'd0};
    rx_vecs[3] = '{4'hD, 1'b1, 16'h0005, 4'b0000, 32'd1};
    rx_vecs[4] = '{4'hD, 1'b1, 16'h0003, 4'b1000, 32'd1};
    rx_vecs[5] = '{4'h0, 1'b1, 16'h0000, 4'b0000, 32'd2};
    rx_vecs[6] = '{4'hF, 1'b1, 16'hFFFC, 4'b0001, 32'd2};

    // Reset values
    tick();
    tick();
    check("rst_ready", 640'(bus.rpc_ready_out), 640'(4'h0));
    check("rst_tx_valid", 640'(bus.net_tx_valid_out), 640'(1'b0));
    check("rst_tx_fields", 640'({bus.net_tx_data_out, bus.net_tx_flow_out, bus.net_tx_addr_out, bus.net_tx_port_out}), 640'(0));
    check("rst_rx", 640'({bus.rpc_valid_out, bus.rpc_data_out, bus.rpc_flow_out}), 640'(0));
    check("rst_drop", 640'(bus.drop_cnt_out), 640'(0));
    check("rst_error", 640'(bus.error), 640'(1'b0));
    reset = 1'b0;
    #1;
    check("ready_after_rst", 640'(bus.rpc_ready_out), 640'(4'hF));

    // RX steering table
    for (int i = 0; i < 7; i++) begin
      bus.port_en_in      = rx_vecs[i].en;
      bus.net_rx_valid_in = rx_vecs[i].vld;
      bus.net_rx_flow_in  = rx_vecs[i].flow;
      bus.net_rx_data_in  = {32{rx_vecs[i].flow ^ 16'h5A5A}};
      tick();
      check($sformatf("rx_strobe_%0d", i), 640'(bus.rpc_valid_out), 640'(rx_vecs[i].exp_strobe));
      check($sformatf("rx_drop_%0d", i), 640'(bus.drop_cnt_out), 640'(rx_vecs[i].exp_drop));
      if (rx_vecs[i].exp_strobe != 4'h0) begin
        check($sformatf("rx_fields_%0d", i), 640'({bus.rpc_data_out, bus.rpc_flow_out}),
              640'({{32{rx_vecs[i].flow ^ 16'h5A5A}}, rx_vecs[i].flow}));
      end
    end
    bus.net_rx_valid_in = 1'b0;
    bus.port_en_in      = 4'hF;
    tick();
    check("rx_strobe_pulse", 640'(bus.rpc_valid_out), 640'(4'h0));

    // Single port: three beats from port 2
    do_reset();
    bus.net_tx_ready_in = 1'b1;
    bus.rpc_valid_in = 4'b0100;
    set_port(2, 16'h0012);
    tick();
    check("sp_latency", 640'(bus.net_tx_valid_out), 640'(1'b0));
    set_port(2, 16'h0013);
    tick();
    check_tx("sp_beat0", 2'd2, 16'h0012);
    set_port(2, 16'h0014);
    tick();
    check_tx("sp_beat1", 2'd2, 16'h0013);
    bus.rpc_valid_in = '0;
    tick();
    check_tx("sp_beat2", 2'd2, 16'h0014);
    tick();
    check("sp_idle", 640'(bus.net_tx_valid_out), 640'(1'b0));

    // Round robin: every port pushes two beats in the same cycles
    do_reset();
    bus.rpc_valid_in = 4'hF;
    for (int n = 0; n < 2; n++) begin
      for (int p = 0; p < NP; p++) set_port(p, 16'(p * 16 + n));
      tick();
    end
    bus.rpc_valid_in = '0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      check_tx($sformatf("rr_%0d", k), 2'(k % 4), 16'((k % 4) * 16 + k / 4));
    end
    tick();
    check("rr_idle", 640'(bus.net_tx_valid_out), 640'(1'b0));

    // Backpressure: output register plus a full FIFO on port 0
    do_reset();
    bus.net_tx_ready_in = 1'b0;
    bus.rpc_valid_in = 4'b0001;
    for (int n = 0; n < 9; n++) begin
      if (n == 8) check("bp_ready_before_full", 640'(bus.rpc_ready_out[0]), 640'(1'b1));
      set_port(0, 16'h0100 + 16'(n));
      tick();
    end
    check("bp_ready_full", 640'(bus.rpc_ready_out[0]), 640'(1'b0));
    set_port(0, 16'h01FF);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_tx($sformatf("bp_stall_%0d", c), 2'd0, 16'h0100);
    end
    bus.net_tx_ready_in = 1'b1;
    tick();
    bus.rpc_valid_in = '0;
    for (int n = 1; n < 9; n++) begin
      if (n > 1) tick();
      check_tx($sformatf("bp_drain_%0d", n), 2'd0, 16'h0100 + 16'(n));
    end
    tick();
    check("bp_no_overflow_push", 640'(bus.net_tx_valid_out), 640'(1'b0));

    // Protocol violation is sticky
    do_reset();
    bus.port_en_in   = 4'b0111;
    bus.rpc_valid_in = 4'b1000;
    tick();
    check("viol_set", 640'(bus.error), 640'(1'b1));
    bus.rpc_valid_in = '0;
    bus.port_en_in   = 4'hF;
    tick();
    tick();
    tick();
    check("viol_sticky", 640'(bus.error), 640'(1'b1));

    // Reset mid-stall: port 2 holds one beat in the register and 5 queued
    bus.net_tx_ready_in = 1'b0;
    bus.rpc_valid_in = 4'b0100;
    for (int n = 0; n < 6; n++) begin
      set_port(2, 16'h0200 + 16'(n));
      tick();
    end
    bus.rpc_valid_in    = '0;
    bus.port_en_in      = 4'b1101;
    bus.net_rx_valid_in = 1'b1;
    bus.net_rx_flow_in  = 16'h0001;
    tick();
    bus.net_rx_valid_in = 1'b0;
    bus.port_en_in      = 4'hF;
    check("mid_drop", 640'(bus.drop_cnt_out), 640'(1));
    check_tx("mid_stall", 2'd2, 16'h0200);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 640'(bus.rpc_ready_out), 640'(4'h0));
    tick();
    reset = 1'b0;
    check("mid_rst_tx_valid", 640'(bus.net_tx_valid_out), 640'(1'b0));
    check("mid_rst_error", 640'(bus.error), 640'(1'b0));
    check("mid_rst_drop", 640'(bus.drop_cnt_out), 640'(0));
    bus.net_tx_ready_in = 1'b1;
    tick();
    tick();
    check("mid_rst_flushed", 640'(bus.net_tx_valid_out), 640'(1'b0));
    bus.rpc_valid_in = 4'b1001;
    set_port(0, 16'h0300);
    set_port(3, 16'h0333);
    tick();
    bus.rpc_valid_in = '0;
    tick();
    check_tx("post_rst_first", 2'd0, 16'h0300);
    tick();
    check_tx("post_rst_second", 2'd3, 16'h0333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
